// File: rtl/proj3_seq_tx.sv
// Burst symbol transmitter: shifts up to eight 2-bit symbols out to a sequence
// detector and records its {z1,z0} responses and the number of z1 hits.
module proj3_seq_tx (
    input  logic        clk,
    input  logic        r,
    input  logic        start,
    input  logic [2:0]  len,
    input  logic [15:0] pattern,
    input  logic        z1_in,
    input  logic        z0_in,
    output logic        x1,
    output logic        x0,
    output logic        sym_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] resp,
    output logic [3:0]  hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] shift_reg, shift_next;
    logic [2:0]  cnt_reg;
    logic [15:0] resp_reg;
    logic [3:0]  hit_reg;

    // Each symbol slot takes the one behind it; the last slot is zero-filled.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            if (gi < 7) begin : g_mid
                assign shift_next[15-2*gi -: 2] = shift_reg[13-2*gi -: 2];
            end else begin : g_last
                assign shift_next[15-2*gi -: 2] = 2'b00;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (cnt_reg == 3'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            state_reg <= IDLE;
            shift_reg <= 16'h0000;
            cnt_reg   <= 3'd0;
            resp_reg  <= 16'h0000;
            hit_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg <= pattern;
                        cnt_reg   <= len;
                        resp_reg  <= 16'h0000;
                        hit_reg   <= 4'd0;
                    end
                end
                SEND: begin
                    shift_reg <= shift_next;
                    resp_reg  <= {resp_reg[13:0], z1_in, z0_in};
                    hit_reg   <= hit_reg + {3'b000, z1_in};
                    if (cnt_reg != 3'd0) cnt_reg <= cnt_reg - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Leftover shift bits after short bursts must not leak onto x1/x0.
    assign sym_valid = (state_reg == SEND);
    assign busy      = (state_reg == SEND);
    assign done      = (state_reg == DONE);
    assign x1        = sym_valid & shift_reg[15];
    assign x0        = sym_valid & shift_reg[14];
    assign resp      = resp_reg;
    assign hit_cnt   = hit_reg;

endmodule

// File: tb/tb_proj3_seq_tx.sv
// Scoreboard bench for proj3_seq_tx: stimulus pushes expected symbols and
// burst results, a negedge monitor pops and compares them.
module tb_proj3_seq_tx;

    logic        clk = 1'b0;
    logic        r = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  len = 3'd0;
    logic [15:0] pattern = 16'h0000;
    logic        z1_in = 1'b0;
    logic        z0_in = 1'b0;
    logic        x1, x0, sym_valid, busy, done;
    logic [15:0] resp;
    logic [3:0]  hit_cnt;

    proj3_seq_tx dut (
        .clk(clk), .r(r), .start(start), .len(len), .pattern(pattern),
        .z1_in(z1_in), .z0_in(z0_in), .x1(x1), .x0(x0),
        .sym_valid(sym_valid), .busy(busy), .done(done),
        .resp(resp), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] sym; int cyc; } sym_t;
    typedef struct { logic [15:0] resp; logic [3:0] hit; int cyc; } done_t;

    sym_t  sym_q[$];
    done_t done_q[$];

    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    logic [15:0] hold_resp = 16'h0000;
    logic [3:0]  hold_hit = 4'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a symbol or a done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sym_valid) begin
                chk("busy_with_sym", {31'd0, busy}, 32'd1);
                if (sym_q.size() == 0) begin
                    chk("unexpected_symbol", 32'd1, 32'd0);
                end else begin
                    sym_t e;
                    e = sym_q.pop_front();
                    chk("symbol", {30'd0, x1, x0}, {30'd0, e.sym});
                    chk("symbol_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_x", {30'd0, x1, x0}, 32'd0);
                chk("idle_busy", {31'd0, busy}, 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("resp", {16'd0, resp}, {16'd0, d.resp});
                    chk("hit_cnt", {28'd0, hit_cnt}, {28'd0, d.hit});
                    hold_resp = d.resp;
                    hold_hit  = d.hit;
                end
            end else if (!sym_valid) begin
                chk("hold_resp", {16'd0, resp}, {16'd0, hold_resp});
                chk("hold_hit", {28'd0, hit_cnt}, {28'd0, hold_hit});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sym_valid"}, {31'd0, sym_valid}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_x"}, {30'd0, x1, x0}, 32'd0);
        chk({tag, "_resp"}, {16'd0, resp}, 32'd0);
        chk({tag, "_hit"}, {28'd0, hit_cnt}, 32'd0);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE with start=b2b.
    task automatic burst(input logic [15:0] pat, input logic [2:0] l, input bit zr,
                         input logic [1:0] zf, input bit noise, input bit b2b);
        logic [1:0]  zs[8];
        logic [15:0] er;
        int          eh;
        int          k;
        int          n;
        n  = int'(l) + 1;
        er = 16'h0000;
        eh = 0;
        for (int i = 0; i < n; i++) begin
            zs[i] = zr ? 2'($urandom) : zf;
            er    = er + (16'(zs[i]) << (2 * (n - 1 - i)));
            eh    = eh + int'(zs[i][1]);
        end
        start   = 1'b1;
        pattern = pat;
        len     = l;
        tick();
        k = cyc;
        for (int i = 0; i < n; i++) begin
            sym_t s;
            s.sym = pat[15 - 2*i -: 2];
            s.cyc = k + i;
            sym_q.push_back(s);
        end
        begin
            done_t d;
            d.resp = er;
            d.hit  = 4'(eh);
            d.cyc  = k + n;
            done_q.push_back(d);
        end
        for (int i = 0; i < n; i++) begin
            z1_in = zs[i][1];
            z0_in = zs[i][0];
            start = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                pattern = 16'($urandom);
                len     = 3'($urandom);
            end
            tick();
        end
        start   = b2b;
        pattern = 16'($urandom);
        len     = 3'($urandom);
        z1_in   = 1'($urandom);
        z0_in   = 1'($urandom);
        tick();
        z1_in = 1'($urandom);
        z0_in = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r = 1'b0;
        tick();
        tick();
        r = 1'b1;
        check_reset_outputs("reset");
        mon_en = 1'b1;
        tick();

        // Reset wins over a simultaneous start.
        r = 1'b0;
        start = 1'b1;
        pattern = 16'hFFFF;
        len = 3'd7;
        tick();
        r = 1'b1;
        start = 1'b0;
        hold_resp = 16'h0000;
        hold_hit = 4'd0;
        check_reset_outputs("reset_vs_start");
        tick();

        burst(16'hE400, 3'd3, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        burst(16'h4000, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0);
        burst(16'hFFFF, 3'd7, 1'b1, 2'b00, 1'b1, 1'b0);
        tick();

        // Abort in the third SEND cycle.
        start = 1'b1;
        pattern = 16'h9C3B;
        len = 3'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sym_t s;
            logic [15:0] p;
            p = 16'h9C3B;
            s.sym = p[15 - 2*i -: 2];
            s.cyc = cyc + i;
            sym_q.push_back(s);
        end
        z1_in = 1'b1;
        tick();
        tick();
        r = 1'b0;
        tick();
        r = 1'b1;
        hold_resp = 16'h0000;
        hold_hit = 4'd0;
        check_reset_outputs("mid_burst_reset");
        tick();
        tick();

        // Start held high across DONE into the following IDLE.
        burst(16'h1B2D, 3'd2, 1'b1, 2'b00, 1'b0, 1'b1);
        burst(16'hA5C3, 3'd4, 1'b1, 2'b00, 1'b0, 1'b0);

        for (int b = 0; b < 40; b++) begin
            bit b2b;
            b2b = (b == 39) ? 1'b0 : 1'($urandom);
            burst(16'($urandom), 3'($urandom_range(0, 7)), 1'b1, 2'b00, 1'($urandom), b2b);
            if (!b2b) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
            end
        end

        start = 1'b0;
        tick();
        tick();
        chk("sym_queue_drained", sym_q.size(), 32'd0);
        chk("done_queue_drained", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/proj3_seq_tx.md
PROJ3_SEQ_TX -- requirements
Module: proj3_seq_tx

Interface
REQ-001 Parameters: none; symbol count fixed at max 8 symbols, each 2 bits wide.
REQ-002 clk  input  1  single clock, all state updates on posedge clk.
REQ-003 r  input  1  reset, synchronous, active-low: sampled only on posedge clk, r=0 resets.
REQ-004 start  input  1  request to transmit a burst, sampled on posedge clk.
REQ-005 len  input  3  burst length minus one (0 -> 1 symbol, 7 -> 8 symbols), sampled with start.
REQ-006 pattern  input  16  symbols to send, symbol 0 in [15:14], symbol 7 in [1:0], sampled with start.
REQ-007 z1_in  input  1  Mealy response bit z1 from the downstream 2-bit sequence detector.
REQ-008 z0_in  input  1  Mealy response bit z0 from the downstream 2-bit sequence detector.
REQ-009 x1  output  1  symbol MSB driven to the detector x1 input.
REQ-010 x0  output  1  symbol LSB driven to the detector x0 input.
REQ-011 sym_valid  output  1  high while x1/x0 carry a burst symbol.
REQ-012 busy  output  1  high while a burst is in progress (SEND state).
REQ-013 done  output  1  one-cycle pulse after the last symbol of a completed burst.
REQ-014 resp  output  16  captured {z1_in,z0_in} pairs, right-justified, oldest pair highest.
REQ-015 hit_cnt  output  4  number of burst cycles in which z1_in was 1.

Function
REQ-016 The block SHALL implement the three-state FSM IDLE, SEND and DONE; all outputs SHALL be driven from registers or decoded from state only, with no combinational path from inputs.
REQ-017 IDLE: x1=x0=0, sym_valid=0, busy=0, done=0; resp and hit_cnt hold their last values.
REQ-018 In IDLE, start=1 at an edge SHALL load pattern into the shift register and len into the symbol counter, clear resp and hit_cnt to 0, and move to SEND.
REQ-019 In SEND, {x1,x0} SHALL equal shift register [15:14], and sym_valid=busy=1.
REQ-020 On each SEND edge, the block SHALL update resp as resp <= {resp[13:0], z1_in, z0_in}.
REQ-021 On each SEND edge, hit_cnt SHALL increment when z1_in=1; 4 bits suffice and no saturation is needed.
REQ-022 On each SEND edge, the shift register SHALL shift left by 2 with zero fill.
REQ-023 On each SEND edge, the counter SHALL decrement when nonzero; when the counter is 0 the FSM SHALL go to DONE.
REQ-024 Latency: with start accepted at edge k, symbol i SHALL be presented in cycle k+1+i, exactly len+1 symbols SHALL be sent, and done SHALL be high during cycle k+len+2 only.
REQ-025 DONE SHALL last one cycle with done=1, sym_valid=0, busy=0, x1=x0=0, then return unconditionally to IDLE.
REQ-026 start SHALL be ignored in SEND and DONE, with no queuing; a start in the cycle after DONE (IDLE) SHALL be accepted.
REQ-027 resp bits above the captured 2*(len+1) bits SHALL remain 0 after a burst.
REQ-028 Changes on pattern or len outside the accepting edge SHALL have no effect on the burst in progress.

Reset
REQ-029 r=0 at an edge SHALL force IDLE and clear the shift register, counter, resp and hit_cnt; all outputs SHALL be 0 after that edge.
REQ-030 Reset SHALL dominate start in the same cycle.
REQ-031 Reset during SEND SHALL abort the burst with no done pulse.
REQ-032 Outputs before the first reset edge are unspecified; the bench SHALL apply r=0 for at least 1 edge before checking.

Verification
REQ-033 Reset priority: r=0 with start=1 -> after the edge busy=0, sym_valid=0, resp=16'h0000, hit_cnt=0.
REQ-034 Basic burst: pattern=16'hE400, len=3, z1_in=1, z0_in=0 -> x1x0 = 11,10,01,00 in cycles k+1..k+4; done in cycle k+5; resp=16'h00AA; hit_cnt=4.
REQ-035 Single symbol: len=0, pattern=16'h4000, z1_in=0, z0_in=1 -> one cycle of x1x0=01 with sym_valid=1, done in the next cycle, resp=16'h0001, hit_cnt=0.
REQ-036 Full burst with ignored start: len=7, pattern=16'hFFFF, start pulsed again during SEND -> 8 symbols of 11, exactly 1 done pulse, no second burst.
REQ-037 Mid-burst reset: r=0 in the 3rd SEND cycle -> the next cycle is IDLE, no done pulse, resp=16'h0000, hit_cnt=0.
REQ-038 Back-to-back: start held high across DONE -> start ignored in the DONE cycle, a new burst accepted in the following IDLE cycle, sym_valid rising 1 cycle later.
